audio_sample_queue: RTL and testbench

AUDIO_SAMPLE_QUEUE -- requirements
Module: audio_sample_queue

---
 rtl/audio_sample_queue.sv | 115 +++++++++++
 tb/tb_audio_sample_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_queue.sv
`default_nettype none
// ============================================================================
// Module : audio_sample_queue
// Stereo 24-bit sample FIFO drained at a fixed sample rate. Counts underruns
// and flags sign changes on each channel.
// Rev    : 1.0  initial release
// ============================================================================
module audio_sample_queue #(
  parameter int CLK_HZ    = 100000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_l,
  input  logic [23:0]              in_r,
  output logic [23:0]              audioL,
  output logic [23:0]              audioR,
  output logic                     pulseL,
  output logic                     pulseR,
  output logic                     sample_tick,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              underruns
);

  localparam int c_DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_AW    = $clog2(DEPTH);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
  localparam logic [c_AW:0]      c_FULL     = (c_AW + 1)'(DEPTH);

  logic [c_DIV_W-1:0] r_div;
  logic [c_AW-1:0]    r_head;
  logic [c_AW-1:0]    r_tail;
  logic [c_AW:0]      r_level;
  logic [23:0]        r_audio_l;
  logic [23:0]        r_audio_r;
  logic               r_pulse_l;
  logic               r_pulse_r;
  logic [15:0]        r_underruns;
  logic [47:0]        r_mem [DEPTH];

  logic               w_tick;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [47:0]        w_head_data;

  // Readiness depends only on the registered fill level, never on this cycle's pop.
  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_empty     = (r_level == '0);
  assign in_ready    = (r_level != c_FULL);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_tick && !w_empty;
  assign w_head_data = r_mem[r_head];

  assign sample_tick = w_tick;
  assign audioL      = r_audio_l;
  assign audioR      = r_audio_r;
  assign pulseL      = r_pulse_l;
  assign pulseR      = r_pulse_r;
  assign level       = r_level;
  assign underruns   = r_underruns;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {in_l, in_r};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_level     <= '0;
      r_audio_l   <= '0;
      r_audio_r   <= '0;
      r_pulse_l   <= 1'b0;
      r_pulse_r   <= 1'b0;
      r_underruns <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + c_DIV_W'(1);

      if (w_push) begin
        r_tail <= r_tail + c_AW'(1);
      end

      // Pulses compare the sign of the outgoing sample with the one it replaces.
      r_pulse_l <= w_pop && (w_head_data[47] != r_audio_l[23]);
      r_pulse_r <= w_pop && (w_head_data[23] != r_audio_r[23]);

      if (w_pop) begin
        r_head    <= r_head + c_AW'(1);
        r_audio_l <= w_head_data[47:24];
        r_audio_r <= w_head_data[23:0];
      end

      if (w_tick && w_empty && (r_underruns != 16'hFFFF)) begin
        r_underruns <= r_underruns + 16'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_AW + 1)'(1);
        2'b01:   r_level <= r_level - (c_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_audio_sample_queue
// Directed stimulus with a scoreboard-driven output monitor for
// audio_sample_queue at its default parameters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_audio_sample_queue;

  localparam int c_DIV   = 2083;
  localparam int c_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_l = '0;
  logic [23:0] in_r = '0;
  logic [23:0] audioL;
  logic [23:0] audioR;
  logic        pulseL;
  logic        pulseR;
  logic        sample_tick;
  logic [4:0]  level;
  logic [15:0] underruns;

  audio_sample_queue #(
    .CLK_HZ    (100000000),
    .SAMPLE_HZ (48000),
    .DEPTH     (c_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_l        (in_l),
    .in_r        (in_r),
    .audioL      (audioL),
    .audioR      (audioR),
    .pulseL      (pulseL),
    .pulseR      (pulseR),
    .sample_tick (sample_tick),
    .level       (level),
    .underruns   (underruns)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        pl;
    logic        pr;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] prev_l = '0;
  logic [23:0] prev_r = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc;

  // Clock edges since the last reset release; phase = cyc % c_DIV.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_push(input logic [23:0] l, input logic [23:0] r);
    exp_q.push_back({l, r, l[23] ^ prev_l[23], r[23] ^ prev_r[23]});
    prev_l = l;
    prev_r = r;
  endtask

  task automatic flush_model();
    exp_q.delete();
    prev_l = '0;
    prev_r = '0;
  endtask

  task automatic to_phase(input int p);
    int n = 0;
    while (((cyc % c_DIV) != p) && (n < 3 * c_DIV)) begin
      @(negedge clk);
      n++;
    end
    check("phase_reached", cyc % c_DIV, p);
  endtask

  function automatic logic [23:0] pat_l(input int k);
    return ((k % 3) == 1) ? (24'h800000 | 24'(k)) : (24'h010000 + 24'(k));
  endfunction

  function automatic logic [23:0] pat_r(input int k);
    return ((k % 2) == 1) ? (24'hF00000 - 24'(k)) : (24'h000200 + 24'(k));
  endfunction

  // Monitor: a tick with data held means new output one cycle later.
  initial begin
    exp_t e;
    logic pend = 1'b0;
    logic post = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        post = 1'b0;
      end else begin
        if (pend) begin
          check("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mon_audioL", audioL, e.l);
            check("mon_audioR", audioR, e.r);
            check("mon_pulseL", pulseL, e.pl);
            check("mon_pulseR", pulseR, e.pr);
          end
          post = 1'b1;
        end else if (post) begin
          check("mon_pulseL_clear", pulseL, 0);
          check("mon_pulseR_clear", pulseR, 0);
          post = 1'b0;
        end
        pend = sample_tick && (level != 0);
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_at[3];
    int tick_seen;
    int idx;
    int early;

    // Reset with a sample offered: nothing may be recorded.
    rst_n = 1'b0; in_valid = 1'b1; in_l = 24'h123456; in_r = 24'h654321;
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_audioL", audioL, 0);
    check("rst_audioR", audioR, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_underruns", underruns, 0);
    check("rst_pulses", {pulseL, pulseR}, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("rel_level", level, 0);

    // Idle run: three ticks, all underruns.
    tick_at = '{-1, -1, -1};
    tick_seen = 0;
    for (int i = 0; i < 3 * c_DIV + 2; i++) begin
      if (sample_tick) begin
        if (tick_seen < 3) tick_at[tick_seen] = i;
        tick_seen++;
      end
      @(negedge clk);
    end
    check("idle_tick0", tick_at[0], 2082);
    check("idle_tick1", tick_at[1], 4165);
    check("idle_tick2", tick_at[2], 6248);
    check("idle_tick_count", tick_seen, 3);
    check("idle_underruns", underruns, 3);
    check("idle_audioL", audioL, 0);
    check("idle_audioR", audioR, 0);

    // Single sample with a right-channel sign change.
    in_valid = 1'b1; in_l = 24'h000100; in_r = 24'hFFFF00;
    check("one_ready", in_ready, 1);
    expect_push(in_l, in_r);
    @(negedge clk);
    in_valid = 1'b0;
    check("one_level1", level, 1);
    to_phase(c_DIV - 1);
    check("one_tick", sample_tick, 1);
    @(negedge clk);
    check("one_level0", level, 0);
    check("one_audioL", audioL, 24'h000100);
    check("one_audioR", audioR, 24'hFFFF00);
    check("one_pulseL", pulseL, 0);
    check("one_pulseR", pulseR, 1);

    // Fill to capacity with valid held high.
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_l = pat_l(idx); in_r = pat_r(idx);
      if (in_ready) begin
        expect_push(in_l, in_r);
        idx++;
      end
      @(negedge clk);
    end
    check("fill_accepted", idx, 16);
    check("fill_level", level, 16);
    check("fill_ready", in_ready, 0);

    // Tick while full: the offered sample is refused, then taken next cycle.
    to_phase(c_DIV - 1);
    check("full_tick", sample_tick, 1);
    check("full_tick_ready", in_ready, 0);
    check("full_tick_level", level, 16);
    @(negedge clk);
    check("full_after_level", level, 15);
    check("full_after_ready", in_ready, 1);
    expect_push(in_l, in_r);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_refill_level", level, 16);
    @(negedge clk);

    // Reset mid-operation discards the FIFO.
    rst_n = 1'b0;
    #1;
    check("midrst_level", level, 0);
    check("midrst_audioL", audioL, 0);
    check("midrst_ready", in_ready, 1);
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Build level 5 with a non-zero output, then reset mid-divider.
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_l = pat_l(k + 3); in_r = pat_r(k + 3);
      check("six_ready", in_ready, 1);
      expect_push(in_l, in_r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("six_level", level, 6);
    to_phase(c_DIV - 1);
    @(negedge clk);
    check("five_level", level, 5);
    to_phase(1000);
    check("five_audioL_nonzero", audioL != 0, 1);
    rst_n = 1'b0;
    #1;
    check("r5_level", level, 0);
    check("r5_audioL", audioL, 0);
    check("r5_audioR", audioR, 0);
    check("r5_underruns", underruns, 0);
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;

    early = 0;
    for (int i = 0; i < c_DIV - 1; i++) begin
      if (sample_tick) early++;
      @(negedge clk);
    end
    check("r5_no_early_tick", early, 0);
    check("r5_tick_at_div", sample_tick, 1);
    // Push into an empty queue on the tick: underrun, no forwarding.
    in_valid = 1'b1; in_l = 24'hABCDEF; in_r = 24'h012345;
    expect_push(in_l, in_r);
    @(negedge clk);
    in_valid = 1'b0;
    check("same_underruns", underruns, 1);
    check("same_level", level, 1);
    check("same_audioL", audioL, 0);
    check("same_audioR", audioR, 0);
    to_phase(c_DIV - 1);
    @(negedge clk);
    check("same_popped_level", level, 0);
    check("same_popped_audioL", audioL, 24'hABCDEF);

    // Underrun counter saturation.
    force dut.r_underruns = 16'hFFFE;
    #1;
    release dut.r_underruns;
    @(negedge clk);
    check("sat_preset", underruns, 16'hFFFE);
    to_phase(c_DIV - 1);
    @(negedge clk);
    check("sat_first", underruns, 16'hFFFF);
    to_phase(c_DIV - 1);
    @(negedge clk);
    check("sat_hold", underruns, 16'hFFFF);
    check("sat_audioL", audioL, 24'hABCDEF);
    check("sat_audioR", audioR, 24'h012345);

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
